// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush scheduler and mult/div busy sequencer for a five-stage pipeline
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_use_D,
  input  logic       md_start_E,
  input  logic       md_is_div_E,
  input  logic       md_use_D,
  input  logic       exc_req_M,
  input  logic       eret_M,
  output logic       stall_F,
  output logic       stall_D,
  output logic       clr_D,
  output logic       clr_E,
  output logic       clr_M,
  output logic [1:0] pc_sel,
  output logic       epc_we,
  output logic       md_busy
);

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_EXC = 2'b01;
  localparam logic [1:0] PC_EPC = 2'b10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             stall;
  logic             flush_run;
  logic             md_start_eff;

  assign md_busy = (md_cnt_q != '0);

  // State and busy-counter registers; reset returns to RUN with an idle unit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Busy counter: a start flushed out of E never loads; otherwise count down to zero and hold.
  always_comb begin
    flush_run    = (state_q == RUN) && (exc_req_M || eret_M);
    md_start_eff = md_start_E && !flush_run;
    md_cnt_d     = md_cnt_q;
    if (md_start_eff) begin
      md_cnt_d = md_is_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  // Next-state and strobe decode: flushes only in RUN (exception beats eret), else the stall rule.
  always_comb begin
    state_d = RUN;
    stall_F = 1'b0;
    stall_D = 1'b0;
    clr_D   = 1'b0;
    clr_E   = 1'b0;
    clr_M   = 1'b0;
    pc_sel  = PC_SEQ;
    epc_we  = 1'b0;
    stall   = load_use_D || (md_use_D && (md_busy || md_start_E));

    if (state_q == RUN && exc_req_M) begin
      pc_sel  = PC_EXC;
      epc_we  = 1'b1;
      clr_D   = 1'b1;
      clr_E   = 1'b1;
      clr_M   = 1'b1;
      state_d = RECOVER;
    end else if (state_q == RUN && eret_M) begin
      pc_sel  = PC_EPC;
      clr_D   = 1'b1;
      clr_E   = 1'b1;
      clr_M   = 1'b1;
      state_d = RECOVER;
    end else if (stall) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      clr_E   = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_use_D, md_start_E, md_is_div_E, md_use_D, exc_req_M, eret_M;
  logic       stall_F, stall_D, clr_D, clr_E, clr_M, epc_we, md_busy;
  logic [1:0] pc_sel;

  typedef struct {
    logic [8:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 1'b0;

  // Expected vector layout: {stall_F, stall_D, clr_D, clr_E, clr_M, pc_sel[1:0], epc_we, md_busy}
  localparam logic [8:0] IDLE   = 9'b000000000;
  localparam logic [8:0] BUSY   = 9'b000000001;
  localparam logic [8:0] STALL  = 9'b110100000;
  localparam logic [8:0] STALLB = 9'b110100001;
  localparam logic [8:0] EXC    = 9'b001110110;
  localparam logic [8:0] EXCB   = 9'b001110111;
  localparam logic [8:0] ERET   = 9'b001111000;

  pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_use_D (load_use_D),
    .md_start_E (md_start_E),
    .md_is_div_E(md_is_div_E),
    .md_use_D   (md_use_D),
    .exc_req_M  (exc_req_M),
    .eret_M     (eret_M),
    .stall_F    (stall_F),
    .stall_D    (stall_D),
    .clr_D      (clr_D),
    .clr_E      (clr_E),
    .clr_M      (clr_M),
    .pc_sel     (pc_sel),
    .epc_we     (epc_we),
    .md_busy    (md_busy)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus: drive inputs just after the edge and post the expected outputs.
  task automatic cyc(input logic lu, input logic ms, input logic md, input logic mu,
                     input logic ex, input logic er, input logic [8:0] e, input string n);
    exp_t it;
    load_use_D  = lu;
    md_start_E  = ms;
    md_is_div_E = md;
    md_use_D    = mu;
    exc_req_M   = ex;
    eret_M      = er;
    it.exp      = e;
    it.name     = n;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, so compare one queued expectation per falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t it;
      logic [8:0] act;
      it  = q.pop_front();
      act = {stall_F, stall_D, clr_D, clr_E, clr_M, pc_sel, epc_we, md_busy};
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b (sF sD cD cE cM pc2 we busy)", it.name, act, it.exp);
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
    end
  end

  initial begin
    reset = 1'b1;
    {load_use_D, md_start_E, md_is_div_E, md_use_D, exc_req_M, eret_M} = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc(0,0,0,0,0,0, IDLE, "reset_state");
    reset = 1'b0;
    cyc(0,0,0,0,0,0, IDLE, "after_reset");

    // Multiply with a dependent instruction held in D from the start cycle
    cyc(0,1,0,1,0,0, STALL, "mul_t0");
    for (int i = 1; i <= 5; i++) cyc(0,0,0,1,0,0, STALLB, $sformatf("mul_t%0d", i));
    cyc(0,0,0,1,0,0, IDLE, "mul_t6_release");
    cyc(0,0,0,0,0,0, IDLE, "mul_idle");

    // Divide, exception at t+3: counter keeps running through the flush
    cyc(0,1,1,0,0,0, IDLE, "div_t0");
    cyc(0,0,0,0,0,0, BUSY, "div_t1");
    cyc(0,0,0,0,0,0, BUSY, "div_t2");
    cyc(0,0,0,0,1,0, EXCB, "div_t3_exc");
    for (int i = 4; i <= 10; i++) cyc(0,0,0,0,0,0, BUSY, $sformatf("div_t%0d", i));
    cyc(0,0,0,0,0,0, IDLE, "div_t11_done");

    // Exception and start together: flushed start never makes the unit busy
    cyc(0,1,0,0,1,0, EXC, "exc_kills_start");
    cyc(0,0,0,0,0,0, IDLE, "no_busy_1");
    cyc(0,0,0,0,0,0, IDLE, "no_busy_2");

    // Exception beats eret; second exception in RECOVER is ignored
    cyc(0,0,0,0,1,1, EXC, "exc_over_eret");
    cyc(0,0,0,0,1,0, IDLE, "recover_ignores_exc");
    cyc(0,0,0,0,0,1, ERET, "eret_flush");
    cyc(0,0,0,0,0,1, IDLE, "recover_ignores_eret");
    cyc(0,0,0,0,1,0, EXC, "exc_again");
    cyc(1,0,0,0,0,0, STALL, "recover_stall");

    // Single-cycle load-use stall
    cyc(1,0,0,0,0,0, STALL, "load_use");
    cyc(0,0,0,0,0,0, IDLE, "load_use_end");

    // Reset asynchronously in RECOVER with md_cnt = 7
    cyc(0,1,1,0,0,0, IDLE, "rst_div_t0");
    cyc(0,0,0,0,0,0, BUSY, "rst_div_t1");
    cyc(0,0,0,0,0,0, BUSY, "rst_div_t2");
    cyc(0,0,0,0,1,0, EXCB, "rst_div_exc");
    reset = 1'b1;
    cyc(0,0,0,0,0,0, IDLE, "async_reset");
    reset = 1'b0;
    cyc(0,0,0,0,1,0, EXC, "run_after_reset");
    cyc(0,0,0,0,0,0, IDLE, "final_idle");

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
